// File: rtl/spram_pwr_seq.sv
`default_nettype none
// ============================================================================
// spram_pwr_seq : request sequencer and power-mode controller for the
//                 16384x16 single-port SPRAM macro
// Rev 1.0
// ============================================================================
module spram_pwr_seq #(
  parameter int AW      = 14,
  parameter int DW      = 16,
  parameter int IDLE_LS = 16,
  parameter int WAKE_LS = 1,
  parameter int WAKE_DS = 8,
  parameter int WAKE_SD = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [3:0]    req_wmask,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  input  logic [1:0]    pwr_req,
  output logic [2:0]    pwr_state,
  output logic          content_lost,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_d,
  output logic [DW-1:0] mem_wem,
  output logic          mem_we,
  output logic          mem_me,
  output logic          mem_ls,
  output logic          mem_ds,
  output logic          mem_sd,
  input  logic [DW-1:0] mem_q
);

  localparam int c_WAKE_LS = (WAKE_LS < 1) ? 1 : WAKE_LS;
  localparam int c_WAKE_DS = (WAKE_DS < 1) ? 1 : WAKE_DS;
  localparam int c_WAKE_SD = (WAKE_SD < 1) ? 1 : WAKE_SD;
  localparam int c_WMAX01  = (c_WAKE_LS > c_WAKE_DS) ? c_WAKE_LS : c_WAKE_DS;
  localparam int c_WMAX    = (c_WMAX01 > c_WAKE_SD) ? c_WMAX01 : c_WAKE_SD;
  localparam int c_WW      = $clog2(c_WMAX + 1);
  localparam int c_IW      = (IDLE_LS > 0) ? $clog2(IDLE_LS + 1) : 1;
  localparam logic [c_IW-1:0] c_IDLE_MAX = c_IW'(IDLE_LS);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_LS     = 3'd1,
    ST_DS     = 3'd2,
    ST_SD     = 3'd3,
    ST_WAKE   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  state_t          r_state;
  logic [c_IW-1:0] r_idle;
  logic [c_WW-1:0] r_wake;
  logic            r_rd_pend;

  logic            w_acc;
  logic            w_inflight;
  logic            w_ls_go;
  logic [c_IW-1:0] w_idle_nxt;
  logic [DW-1:0]   w_wem;

  for (genvar gi = 0; gi < DW; gi++) begin : g_wem
    assign w_wem[gi] = req_wmask[gi/4];
  end

  assign req_ready  = rst_n && (r_state == ST_ACTIVE) && !pwr_req[1];
  assign w_acc      = req_valid && req_ready;
  assign w_inflight = r_rd_pend || rsp_valid;
  assign w_idle_nxt = (r_idle == c_IDLE_MAX) ? r_idle : r_idle + 1'b1;
  // Light sleep is entered on the edge at which the idle count reaches its limit.
  assign w_ls_go    = (IDLE_LS != 0) && !w_acc && !w_inflight && (w_idle_nxt == c_IDLE_MAX);

  assign rsp_rdata  = mem_q;
  assign pwr_state  = (r_state == ST_GAP) ? ST_DS : r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ACTIVE;
      r_idle       <= '0;
      r_wake       <= '0;
      r_rd_pend    <= 1'b0;
      rsp_valid    <= 1'b0;
      content_lost <= 1'b0;
      mem_adr      <= '0;
      mem_d        <= '0;
      mem_wem      <= '0;
      mem_we       <= 1'b0;
      mem_me       <= 1'b0;
      mem_ls       <= 1'b0;
      mem_ds       <= 1'b0;
      mem_sd       <= 1'b0;
    end else begin
      mem_me       <= w_acc;
      mem_we       <= w_acc && req_we;
      r_rd_pend    <= w_acc && !req_we;
      rsp_valid    <= r_rd_pend;
      content_lost <= 1'b0;
      if (w_acc) begin
        mem_adr <= req_addr;
        mem_d   <= req_wdata;
        mem_wem <= w_wem;
      end

      case (r_state)
        ST_ACTIVE: begin
          r_idle <= w_acc ? '0 : w_idle_nxt;
          if (pwr_req[1] && !w_inflight) begin
            r_state <= pwr_req[0] ? ST_SD : ST_DS;
            mem_ds  <= !pwr_req[0];
            mem_sd  <= pwr_req[0];
          end else if (w_ls_go) begin
            r_state <= ST_LS;
            mem_ls  <= 1'b1;
          end
        end
        ST_LS: begin
          if (pwr_req[1]) begin
            mem_ls  <= 1'b0;
            r_state <= pwr_req[0] ? ST_SD : ST_DS;
            mem_ds  <= !pwr_req[0];
            mem_sd  <= pwr_req[0];
          end else if (req_valid) begin
            mem_ls  <= 1'b0;
            r_state <= ST_WAKE;
            r_wake  <= c_WW'(c_WAKE_LS);
          end
        end
        ST_DS: begin
          // SD may only rise after DS has been low for a full cycle.
          if (pwr_req == 2'b11) begin
            mem_ds  <= 1'b0;
            r_state <= ST_GAP;
          end else if (!pwr_req[1]) begin
            mem_ds  <= 1'b0;
            r_state <= ST_WAKE;
            r_wake  <= c_WW'(c_WAKE_DS);
          end
        end
        ST_GAP: begin
          mem_sd  <= 1'b1;
          r_state <= ST_SD;
        end
        ST_SD: begin
          if (!pwr_req[1]) begin
            mem_sd       <= 1'b0;
            content_lost <= 1'b1;
            r_state      <= ST_WAKE;
            r_wake       <= c_WW'(c_WAKE_SD);
          end
        end
        ST_WAKE: begin
          if (r_wake <= c_WW'(1)) begin
            r_state <= ST_ACTIVE;
            r_idle  <= '0;
          end else begin
            r_wake <= r_wake - 1'b1;
          end
        end
        default: r_state <= ST_ACTIVE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spram_pwr_seq.sv
`default_nettype none
// tb_spram_pwr_seq : self-checking bench for spram_pwr_seq with a behavioural
//                    SPRAM macro and a read-response scoreboard.
module tb_spram_pwr_seq;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int NV = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wmask = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    pwr_req = 2'b00;
  logic [2:0]    pwr_state;
  logic          content_lost;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_wem;
  logic          mem_we;
  logic          mem_me;
  logic          mem_ls;
  logic          mem_ds;
  logic          mem_sd;
  logic [DW-1:0] mem_q = '0;

  always #5 clk = ~clk;

  spram_pwr_seq #(
    .AW(AW), .DW(DW), .IDLE_LS(16), .WAKE_LS(1), .WAKE_DS(8), .WAKE_SD(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .pwr_req(pwr_req), .pwr_state(pwr_state), .content_lost(content_lost),
    .mem_adr(mem_adr), .mem_d(mem_d), .mem_wem(mem_wem), .mem_we(mem_we),
    .mem_me(mem_me), .mem_ls(mem_ls), .mem_ds(mem_ds), .mem_sd(mem_sd),
    .mem_q(mem_q)
  );

  // Behavioural macro: samples pins on the rising edge, registered Q.
  logic [DW-1:0] macro_arr [0:(1<<AW)-1];
  logic [DW-1:0] nv;
  always @(posedge clk) begin
    if (mem_me) begin
      if (mem_we) begin
        nv = macro_arr[mem_adr];
        nv = (nv & ~mem_wem) | (mem_d & mem_wem);
        macro_arr[mem_adr] <= nv;
      end else begin
        mem_q <= macro_arr[mem_adr];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    mask;
    logic [DW-1:0] exp_wem;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vecs[NV];

  // Response checker plus pin-legality rules, every cycle out of reset.
  exp_t mon_e;
  logic prev_ds = 1'b0;
  logic prev_sd = 1'b0;
  logic [2:0] viol;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.data));
          check("rsp_latency", 64'(cyc), 64'(mon_e.due));
        end
      end
      viol[0] = mem_me && (pwr_state != 3'd0);
      viol[1] = ($countones({mem_ls, mem_ds, mem_sd}) > 1);
      viol[2] = mem_sd && !prev_sd && prev_ds;
      check("pin_rules", 64'(viol), 64'd0);
    end
    prev_ds = mem_ds;
    prev_sd = mem_sd;
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] m, input logic [DW-1:0] exp_r, output logic ok);
    int w;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    w = 0; ok = 1'b0;
    #1;
    while (!req_ready && w < 100) begin
      @(negedge clk); #1; w++;
    end
    if (!req_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      @(negedge clk);
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      if (!we) sb.push_back('{exp_r, cyc + 1});
      ok = 1'b1;
    end
  endtask

  task automatic wake_len(output int n, output int bad);
    n = 0; bad = 0;
    while (pwr_state == 3'd4 && n < 200) begin
      n++;
      if (req_ready || mem_me || (n > 1 && content_lost)) bad++;
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit);
    int w;
    w = 0;
    while (pwr_state != s && w < limit) begin
      @(negedge clk); w++;
    end
    check("wait_state", 64'(pwr_state), 64'(s));
  endtask

  initial begin
    logic ok;
    int t0, c0, n, bad, last_acc;

    vecs[0]  = '{1'b1, 14'h1234, 16'hA5C3, 4'b1111, 16'hFFFF, 16'h0000};
    vecs[1]  = '{1'b0, 14'h1234, 16'h0000, 4'b0000, 16'h0000, 16'hA5C3};
    vecs[2]  = '{1'b1, 14'h0040, 16'hFFFF, 4'b1111, 16'hFFFF, 16'h0000};
    vecs[3]  = '{1'b1, 14'h0040, 16'h0000, 4'b0010, 16'h00F0, 16'h0000};
    vecs[4]  = '{1'b0, 14'h0040, 16'h0000, 4'b0000, 16'h0000, 16'hFF0F};
    vecs[5]  = '{1'b1, 14'h3FFF, 16'hBEEF, 4'b1111, 16'hFFFF, 16'h0000};
    vecs[6]  = '{1'b1, 14'h3FFF, 16'h1234, 4'b1001, 16'hF00F, 16'h0000};
    vecs[7]  = '{1'b0, 14'h3FFF, 16'h0000, 4'b0000, 16'h0000, 16'h1EE4};
    vecs[8]  = '{1'b1, 14'h0000, 16'hC3C3, 4'b1111, 16'hFFFF, 16'h0000};
    vecs[9]  = '{1'b1, 14'h0000, 16'h5A5A, 4'b0000, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 14'h0000, 16'h0000, 4'b0000, 16'h0000, 16'hC3C3};
    vecs[11] = '{1'b0, 14'h1234, 16'h0000, 4'b0000, 16'h0000, 16'hA5C3};

    repeat (3) @(negedge clk);
    check("rst_mem_pins", {mem_adr, mem_d, mem_wem, mem_we, mem_me, mem_ls, mem_ds, mem_sd}, 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_pwr_state", 64'(pwr_state), 64'd0);
    check("rst_content_lost", 64'(content_lost), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Back-to-back table traffic.
    t0 = cyc;
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].exp_rdata, ok);
      if (ok) begin
        check("vec_me", 64'(mem_me), 64'd1);
        check("vec_we", 64'(mem_we), 64'(vecs[i].we));
        check("vec_adr", 64'(mem_adr), 64'(vecs[i].addr));
        if (vecs[i].we) begin
          check("vec_wem", 64'(mem_wem), 64'(vecs[i].exp_wem));
          check("vec_d", 64'(mem_d), 64'(vecs[i].wdata));
        end
      end
    end
    check("throughput_cycles", 64'(cyc - t0), 64'(NV));
    last_acc = acc_cyc;
    req_valid = 1'b0;
    @(negedge clk);
    check("idle_me", 64'(mem_me), 64'd0);
    check("idle_we", 64'(mem_we), 64'd0);

    // Auto light-sleep after 16 idle cycles.
    wait_state(3'd1, 40);
    check("ls_entry_cycle", 64'(cyc), 64'(last_acc + 16));
    check("ls_pin", 64'(mem_ls), 64'd1);
    check("ls_ready", 64'(req_ready), 64'd0);

    // Wake from LS by a read.
    c0 = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0040;
    @(negedge clk);
    check("lswake_state", 64'(pwr_state), 64'd4);
    check("lswake_ls", 64'(mem_ls), 64'd0);
    check("lswake_ready", 64'(req_ready), 64'd0);
    issue(1'b0, 14'h0040, 16'h0000, 4'b0000, 16'hFF0F, ok);
    check("lswake_accept_cycle", 64'(acc_cyc), 64'(c0 + 3));
    req_valid = 1'b0;

    // DS request the cycle after a read accept: entry waits for the response.
    c0 = acc_cyc;
    pwr_req = 2'b10;
    #1;
    check("ds_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("ds_wait_rsp", 64'({rsp_valid, mem_ds}), 64'b10);
    @(negedge clk);
    check("ds_wait_drain", 64'({pwr_state, mem_ds}), 64'd0);
    @(negedge clk);
    check("ds_entry", 64'({pwr_state, mem_ds}), {60'd0, 3'd2, 1'b1});
    check("ds_entry_cycle", 64'(cyc), 64'(c0 + 3));
    repeat (3) @(negedge clk);

    // DS -> gap -> SD, hold in SD with 10, then exit.
    pwr_req = 2'b11;
    @(negedge clk);
    check("gap_pins", 64'({mem_ls, mem_ds, mem_sd, mem_me}), 64'd0);
    @(negedge clk);
    check("sd_entry", 64'({pwr_state, mem_sd}), {60'd0, 3'd3, 1'b1});
    pwr_req = 2'b10;
    repeat (3) @(negedge clk);
    check("sd_hold", 64'({pwr_state, mem_sd}), {60'd0, 3'd3, 1'b1});
    pwr_req = 2'b00;
    @(negedge clk);
    check("sd_exit", 64'({pwr_state, mem_sd, content_lost}), {59'd0, 3'd4, 1'b0, 1'b1});
    wake_len(n, bad);
    check("sd_wake_cycles", 64'(n), 64'd32);
    check("sd_wake_rules", 64'(bad), 64'd0);
    check("sd_wake_done", 64'({pwr_state, req_ready, content_lost}), 64'b00010);

    issue(1'b1, 14'h0100, 16'h1357, 4'b1111, 16'h0000, ok);
    issue(1'b0, 14'h0100, 16'h0000, 4'b0000, 16'h1357, ok);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // ACTIVE -> DS -> WAKE(8).
    pwr_req = 2'b10;
    @(negedge clk);
    check("ds2_state", 64'(pwr_state), 64'd2);
    pwr_req = 2'b00;
    @(negedge clk);
    check("ds2_exit", 64'({pwr_state, mem_ds}), {60'd0, 3'd4, 1'b0});
    wake_len(n, bad);
    check("ds_wake_cycles", 64'(n), 64'd8);
    check("ds_wake_rules", 64'(bad), 64'd0);

    // ACTIVE -> SD directly.
    pwr_req = 2'b11;
    @(negedge clk);
    check("sd_direct", 64'({pwr_state, mem_ds, mem_sd}), {59'd0, 3'd3, 1'b0, 1'b1});
    pwr_req = 2'b01;
    @(negedge clk);
    check("sd2_content_lost", 64'(content_lost), 64'd1);
    wake_len(n, bad);
    check("sd2_wake_cycles", 64'(n), 64'd32);
    check("pwr01_ready", 64'(req_ready), 64'd1);
    pwr_req = 2'b00;

    // LS -> DS directly.
    wait_state(3'd1, 40);
    pwr_req = 2'b10;
    @(negedge clk);
    check("ls_to_ds", 64'({pwr_state, mem_ls, mem_ds}), {59'd0, 3'd2, 1'b0, 1'b1});
    pwr_req = 2'b00;
    @(negedge clk);
    wake_len(n, bad);
    check("ls_ds_wake_cycles", 64'(n), 64'd8);

    // Reset while a read response is being presented.
    issue(1'b0, 14'h1234, 16'h0000, 4'b0000, 16'hA5C3, ok);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_reset_rsp", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_mem_pins", {mem_adr, mem_d, mem_wem, mem_we, mem_me, mem_ls, mem_ds, mem_sd}, 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", 64'({pwr_state, req_ready, rsp_valid}), 64'b00010);
    issue(1'b0, 14'h1234, 16'h0000, 4'b0000, 16'hA5C3, ok);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
